// File: rtl/multicycle_ctrl_pkg.sv
// Shared types, opcode constants and datapath mux-select codes for the RV32I control path.
package multicycle_ctrl_pkg;

    localparam int unsigned STATE_W  = 3;
    localparam int unsigned OPCODE_W = 7;
    localparam int unsigned SEL_W    = 2;
    localparam int unsigned WAIT_W   = 8;

    typedef enum logic [STATE_W-1:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE   = 4'd0,
        CLS_LOAD   = 4'd1,
        CLS_STORE  = 4'd2,
        CLS_OPIMM  = 4'd3,
        CLS_OP     = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_BRANCH = 4'd9,
        CLS_FENCE  = 4'd10
    } iclass_e;

    localparam logic [OPCODE_W-1:0] OPC_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OPC_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [OPCODE_W-1:0] OPC_OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OPC_LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_W-1:0] OPC_JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] OPC_JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] OPC_BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OPC_FENCE  = 7'b0001111;

    // Register-file write source
    localparam logic [SEL_W-1:0] WSRC_ALU   = 2'd0;
    localparam logic [SEL_W-1:0] WSRC_MEM   = 2'd1;
    localparam logic [SEL_W-1:0] WSRC_PC4   = 2'd2;
    // ALU operand A
    localparam logic [SEL_W-1:0] ASRC_RS1   = 2'd0;
    localparam logic [SEL_W-1:0] ASRC_PC    = 2'd1;
    localparam logic [SEL_W-1:0] ASRC_ZERO  = 2'd2;
    // ALU operand B
    localparam logic [SEL_W-1:0] BSRC_RS2   = 2'd0;
    localparam logic [SEL_W-1:0] BSRC_IMM   = 2'd1;
    localparam logic [SEL_W-1:0] BSRC_FOUR  = 2'd2;
    // ALU operation
    localparam logic [SEL_W-1:0] ALUOP_ADD  = 2'd0;
    localparam logic [SEL_W-1:0] ALUOP_SUB  = 2'd1;
    localparam logic [SEL_W-1:0] ALUOP_FUNC = 2'd2;
    // Next-PC source
    localparam logic [SEL_W-1:0] PCSRC_PC4  = 2'd0;
    localparam logic [SEL_W-1:0] PCSRC_ALU  = 2'd1;
    localparam logic [SEL_W-1:0] PCSRC_JALR = 2'd2;

    // Map an opcode to its instruction class; CLS_NONE marks an illegal opcode.
    function automatic iclass_e decode_class(input logic [OPCODE_W-1:0] opc);
        iclass_e c;
        case (opc)
            OPC_LOAD:   c = CLS_LOAD;
            OPC_STORE:  c = CLS_STORE;
            OPC_OPIMM:  c = CLS_OPIMM;
            OPC_OP:     c = CLS_OP;
            OPC_LUI:    c = CLS_LUI;
            OPC_AUIPC:  c = CLS_AUIPC;
            OPC_JAL:    c = CLS_JAL;
            OPC_JALR:   c = CLS_JALR;
            OPC_BRANCH: c = CLS_BRANCH;
            OPC_FENCE:  c = CLS_FENCE;
            default:    c = CLS_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control/datapath bundle between the multicycle controller and the RV32I datapath.
interface multicycle_ctrl_if #(
    parameter int unsigned INSTRET_W = 32
);
    import multicycle_ctrl_pkg::*;

    logic [OPCODE_W-1:0]  i_opcode;
    logic                 i_branch_taken;
    logic                 i_mem_ready;
    logic                 o_mem_req;
    logic                 o_mem_we;
    logic                 o_mem_addr_src;
    logic                 o_ir_we;
    logic                 o_rf_we;
    logic [SEL_W-1:0]     o_rf_wsrc;
    logic [SEL_W-1:0]     o_alu_a_src;
    logic [SEL_W-1:0]     o_alu_b_src;
    logic [SEL_W-1:0]     o_alu_op;
    logic                 o_pc_we;
    logic [SEL_W-1:0]     o_pc_src;
    logic                 o_retire;
    logic [INSTRET_W-1:0] o_instret;
    logic                 o_illegal;
    logic [STATE_W-1:0]   o_state;

    // Datapath side: supplies opcode/status, consumes controls
    modport master (
        output i_opcode, i_branch_taken, i_mem_ready,
        input  o_mem_req, o_mem_we, o_mem_addr_src, o_ir_we, o_rf_we, o_rf_wsrc,
               o_alu_a_src, o_alu_b_src, o_alu_op, o_pc_we, o_pc_src,
               o_retire, o_instret, o_illegal, o_state
    );

    // Controller side
    modport slave (
        input  i_opcode, i_branch_taken, i_mem_ready,
        output o_mem_req, o_mem_we, o_mem_addr_src, o_ir_we, o_rf_we, o_rf_wsrc,
               o_alu_a_src, o_alu_b_src, o_alu_op, o_pc_we, o_pc_src,
               o_retire, o_instret, o_illegal, o_state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/wb sequencing, memory
// handshake with optional wait timeout, sticky illegal trap and instret counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 0,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                i_clk,
    input  logic                i_rst,
    multicycle_ctrl_if.slave    bus
);

    localparam int unsigned WAIT_EXT_W = WAIT_W + 1;

    state_e               state_q, state_d;
    iclass_e              cls_q, cls_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 illegal_q, illegal_d;

    logic                 mem_req_c, mem_we_c, mem_addr_src_c, ir_we_c, rf_we_c;
    logic [SEL_W-1:0]     rf_wsrc_c, alu_a_src_c, alu_b_src_c, alu_op_c, pc_src_c;
    logic                 pc_we_c, retire_c;
    logic [WAIT_EXT_W-1:0] wait_inc_c;
    logic                 timeout_hit_c;

    // Current wait cycle is the last one allowed before trapping
    assign wait_inc_c    = {1'b0, wait_q} + WAIT_EXT_W'(1);
    assign timeout_hit_c = (MEM_TIMEOUT != 32'd0) &&
                           (wait_inc_c == WAIT_EXT_W'(MEM_TIMEOUT));

    // Next-state and Moore/gated control decode; everything idles during reset
    always_comb begin
        state_d        = state_q;
        cls_d          = cls_q;
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_src_c = 1'b0;
        ir_we_c        = 1'b0;
        rf_we_c        = 1'b0;
        rf_wsrc_c      = WSRC_ALU;
        alu_a_src_c    = ASRC_RS1;
        alu_b_src_c    = BSRC_RS2;
        alu_op_c       = ALUOP_ADD;
        pc_we_c        = 1'b0;
        pc_src_c       = PCSRC_PC4;
        retire_c       = 1'b0;

        if (!i_rst) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req_c = 1'b1;
                    if (bus.i_mem_ready) begin
                        ir_we_c = 1'b1;
                        state_d = ST_DECODE;
                    end else if (timeout_hit_c) begin
                        state_d = ST_TRAP;
                    end
                end
                ST_DECODE: begin
                    cls_d   = decode_class(bus.i_opcode);
                    state_d = (cls_d == CLS_NONE) ? ST_TRAP : ST_EXEC;
                end
                ST_EXEC: begin
                    case (cls_q)
                        CLS_LOAD, CLS_STORE: begin
                            alu_b_src_c = BSRC_IMM;
                            state_d     = ST_MEM;
                        end
                        CLS_OP: begin
                            alu_op_c = ALUOP_FUNC;
                            state_d  = ST_WB;
                        end
                        CLS_OPIMM: begin
                            alu_b_src_c = BSRC_IMM;
                            alu_op_c    = ALUOP_FUNC;
                            state_d     = ST_WB;
                        end
                        CLS_LUI: begin
                            alu_a_src_c = ASRC_ZERO;
                            alu_b_src_c = BSRC_IMM;
                            state_d     = ST_WB;
                        end
                        CLS_AUIPC, CLS_JAL: begin
                            alu_a_src_c = ASRC_PC;
                            alu_b_src_c = BSRC_IMM;
                            state_d     = ST_WB;
                        end
                        CLS_JALR: begin
                            alu_b_src_c = BSRC_IMM;
                            state_d     = ST_WB;
                        end
                        CLS_BRANCH: begin
                            // ALU forms the target; the comparator is separate in the datapath
                            alu_a_src_c = ASRC_PC;
                            alu_b_src_c = BSRC_IMM;
                            pc_we_c     = 1'b1;
                            pc_src_c    = bus.i_branch_taken ? PCSRC_ALU : PCSRC_PC4;
                            retire_c    = 1'b1;
                            state_d     = ST_FETCH;
                        end
                        CLS_FENCE: begin
                            pc_we_c  = 1'b1;
                            retire_c = 1'b1;
                            state_d  = ST_FETCH;
                        end
                        default: state_d = ST_TRAP;
                    endcase
                end
                ST_MEM: begin
                    mem_req_c      = 1'b1;
                    mem_addr_src_c = 1'b1;
                    mem_we_c       = (cls_q == CLS_STORE);
                    if (bus.i_mem_ready) begin
                        if (cls_q == CLS_STORE) begin
                            pc_we_c  = 1'b1;
                            retire_c = 1'b1;
                            state_d  = ST_FETCH;
                        end else begin
                            state_d  = ST_WB;
                        end
                    end else if (timeout_hit_c) begin
                        state_d = ST_TRAP;
                    end
                end
                ST_WB: begin
                    rf_we_c  = 1'b1;
                    pc_we_c  = 1'b1;
                    retire_c = 1'b1;
                    state_d  = ST_FETCH;
                    case (cls_q)
                        CLS_LOAD: rf_wsrc_c = WSRC_MEM;
                        CLS_JAL: begin
                            rf_wsrc_c = WSRC_PC4;
                            pc_src_c  = PCSRC_ALU;
                        end
                        CLS_JALR: begin
                            rf_wsrc_c = WSRC_PC4;
                            pc_src_c  = PCSRC_JALR;
                        end
                        default: ;
                    endcase
                end
                ST_TRAP: state_d = ST_TRAP;
                default: state_d = ST_TRAP;
            endcase
        end

        // Wait counter restarts on every state change, saturates, counts stalled requests
        if (state_d != state_q) begin
            wait_d = '0;
        end else if (mem_req_c && !bus.i_mem_ready && (wait_q != {WAIT_W{1'b1}})) begin
            wait_d = wait_q + WAIT_W'(1);
        end else begin
            wait_d = wait_q;
        end

        instret_d = instret_q + INSTRET_W'(retire_c);
        illegal_d = illegal_q | (state_d == ST_TRAP);
    end

    // State, class, wait counter, retire counter and trap flag registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_FETCH;
            cls_q     <= CLS_NONE;
            wait_q    <= '0;
            instret_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.o_mem_req      = mem_req_c;
    assign bus.o_mem_we       = mem_we_c;
    assign bus.o_mem_addr_src = mem_addr_src_c;
    assign bus.o_ir_we        = ir_we_c;
    assign bus.o_rf_we        = rf_we_c;
    assign bus.o_rf_wsrc      = rf_wsrc_c;
    assign bus.o_alu_a_src    = alu_a_src_c;
    assign bus.o_alu_b_src    = alu_b_src_c;
    assign bus.o_alu_op       = alu_op_c;
    assign bus.o_pc_we        = pc_we_c;
    assign bus.o_pc_src       = pc_src_c;
    assign bus.o_retire       = retire_c;
    assign bus.o_instret      = instret_q;
    assign bus.o_illegal      = illegal_q;
    assign bus.o_state        = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Cycle-accurate bench for multicycle_ctrl: one instance without timeout, one with MEM_TIMEOUT=4.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0]  st;
        logic        req;
        logic        we;
        logic        asrc;
        logic        irwe;
        logic        rfwe;
        logic [1:0]  wsrc;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [1:0]  op;
        logic        pcwe;
        logic [1:0]  pcsrc;
        logic        ret;
        logic        ill;
        logic [31:0] instret;
    } out_t;

    typedef struct packed {
        logic [6:0] opc;
        logic       tk;
        logic       rdy;
    } in_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    typedef struct {
        bit   sel;
        out_t exp;
    } sb_t;

    logic clk = 1'b0;
    logic rst0, rst1;
    int   n_vec  = 0;
    int   n_fail = 0;
    vec_t tbl[$];
    sb_t  sbq[$];

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.INSTRET_W(32)) bus0();
    multicycle_ctrl_if #(.INSTRET_W(32)) bus1();

    multicycle_ctrl #(.MEM_TIMEOUT(0), .INSTRET_W(32)) dut0 (
        .i_clk(clk), .i_rst(rst0), .bus(bus0)
    );
    multicycle_ctrl #(.MEM_TIMEOUT(4), .INSTRET_W(32)) dut1 (
        .i_clk(clk), .i_rst(rst1), .bus(bus1)
    );

    out_t act0, act1;
    assign act0 = {bus0.o_state, bus0.o_mem_req, bus0.o_mem_we, bus0.o_mem_addr_src,
                   bus0.o_ir_we, bus0.o_rf_we, bus0.o_rf_wsrc, bus0.o_alu_a_src,
                   bus0.o_alu_b_src, bus0.o_alu_op, bus0.o_pc_we, bus0.o_pc_src,
                   bus0.o_retire, bus0.o_illegal, bus0.o_instret};
    assign act1 = {bus1.o_state, bus1.o_mem_req, bus1.o_mem_we, bus1.o_mem_addr_src,
                   bus1.o_ir_we, bus1.o_rf_we, bus1.o_rf_wsrc, bus1.o_alu_a_src,
                   bus1.o_alu_b_src, bus1.o_alu_op, bus1.o_pc_we, bus1.o_pc_src,
                   bus1.o_retire, bus1.o_illegal, bus1.o_instret};

    function automatic out_t mk(input int st, input int req, input int we, input int asrc,
                                input int irwe, input int rfwe, input int wsrc, input int a,
                                input int b, input int op, input int pcwe, input int pcsrc,
                                input int ret, input int ill, input int n);
        out_t r;
        r.st = 3'(st);     r.req = 1'(req);     r.we = 1'(we);       r.asrc = 1'(asrc);
        r.irwe = 1'(irwe); r.rfwe = 1'(rfwe);   r.wsrc = 2'(wsrc);   r.a = 2'(a);
        r.b = 2'(b);       r.op = 2'(op);       r.pcwe = 1'(pcwe);   r.pcsrc = 2'(pcsrc);
        r.ret = 1'(ret);   r.ill = 1'(ill);     r.instret = 32'(n);
        return r;
    endfunction

    // Expected outputs per state, straight from the control table
    function automatic out_t x_f(input int n, input int rdy);
        return mk(0, 1, 0, 0, rdy, 0, 0, 0, 0, 0, 0, 0, 0, 0, n);
    endfunction
    function automatic out_t x_d(input int n);
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, n);
    endfunction
    function automatic out_t x_e(input int n, input int a, input int b, input int op,
                                 input int pcwe, input int pcsrc, input int ret);
        return mk(2, 0, 0, 0, 0, 0, 0, a, b, op, pcwe, pcsrc, ret, 0, n);
    endfunction
    function automatic out_t x_m(input int n, input int we, input int done);
        return mk(3, 1, we, 1, 0, 0, 0, 0, 0, 0, done, 0, done, 0, n);
    endfunction
    function automatic out_t x_w(input int n, input int wsrc, input int pcsrc);
        return mk(4, 0, 0, 0, 0, 1, wsrc, 0, 0, 0, 1, pcsrc, 1, 0, n);
    endfunction
    function automatic out_t x_t(input int n);
        return mk(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, n);
    endfunction

    task automatic add(input logic [6:0] opc, input logic tk, input logic rdy, input out_t e);
        vec_t v;
        v.in  = '{opc, tk, rdy};
        v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic check_sb();
        sb_t  s;
        out_t a;
        s = sbq.pop_front();
        a = s.sel ? act1 : act0;
        n_vec++;
        if (a !== s.exp) begin
            n_fail++;
            $display("FAIL vec%0d dut%0d: got st=%0d fields=%h, want st=%0d fields=%h",
                     n_vec, s.sel, a.st, a, s.exp.st, s.exp);
        end
    endtask

    // One clock of stimulus on the selected instance; result checked at the falling edge
    task automatic step(input bit sel, input in_t in, input out_t e);
        sb_t s;
        if (!sel) begin
            bus0.i_opcode = in.opc; bus0.i_branch_taken = in.tk; bus0.i_mem_ready = in.rdy;
        end else begin
            bus1.i_opcode = in.opc; bus1.i_branch_taken = in.tk; bus1.i_mem_ready = in.rdy;
        end
        s.sel = sel;
        s.exp = e;
        sbq.push_back(s);
        @(negedge clk);
        check_sb();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic reset_dut(input bit sel);
        if (!sel) rst0 = 1'b1; else rst1 = 1'b1;
        @(posedge clk);
        #1;
        if (!sel) rst0 = 1'b0; else rst1 = 1'b0;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1;
        bus0.i_opcode = '0; bus0.i_branch_taken = 1'b0; bus0.i_mem_ready = 1'b0;
        bus1.i_opcode = '0; bus1.i_branch_taken = 1'b0; bus1.i_mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;

        // ADDI, ready tied high: 0,1,2,4
        add(7'h13, 0, 1, x_f(0, 1)); add(7'h13, 0, 1, x_d(0));
        add(7'h13, 0, 1, x_e(0, 0, 1, 2, 0, 0, 0)); add(7'h13, 0, 1, x_w(0, 0, 0));
        // LW with three MEM stalls
        add(7'h03, 0, 1, x_f(1, 1)); add(7'h03, 0, 1, x_d(1));
        add(7'h03, 0, 1, x_e(1, 0, 1, 0, 0, 0, 0));
        add(7'h03, 0, 0, x_m(1, 0, 0)); add(7'h03, 0, 0, x_m(1, 0, 0));
        add(7'h03, 0, 0, x_m(1, 0, 0)); add(7'h03, 0, 1, x_m(1, 0, 0));
        add(7'h03, 0, 1, x_w(1, 1, 0));
        // SW, zero wait
        add(7'h23, 0, 1, x_f(2, 1)); add(7'h23, 0, 1, x_d(2));
        add(7'h23, 0, 1, x_e(2, 0, 1, 0, 0, 0, 0)); add(7'h23, 0, 1, x_m(2, 1, 1));
        // Branch taken then not taken
        add(7'h63, 1, 1, x_f(3, 1)); add(7'h63, 1, 1, x_d(3));
        add(7'h63, 1, 1, x_e(3, 1, 1, 0, 1, 1, 1));
        add(7'h63, 0, 1, x_f(4, 1)); add(7'h63, 0, 1, x_d(4));
        add(7'h63, 0, 1, x_e(4, 1, 1, 0, 1, 0, 1));
        // JAL, JALR, LUI, AUIPC, OP
        add(7'h6F, 0, 1, x_f(5, 1)); add(7'h6F, 0, 1, x_d(5));
        add(7'h6F, 0, 1, x_e(5, 1, 1, 0, 0, 0, 0)); add(7'h6F, 0, 1, x_w(5, 2, 1));
        add(7'h67, 0, 1, x_f(6, 1)); add(7'h67, 0, 1, x_d(6));
        add(7'h67, 0, 1, x_e(6, 0, 1, 0, 0, 0, 0)); add(7'h67, 0, 1, x_w(6, 2, 2));
        add(7'h37, 0, 1, x_f(7, 1)); add(7'h37, 0, 1, x_d(7));
        add(7'h37, 0, 1, x_e(7, 2, 1, 0, 0, 0, 0)); add(7'h37, 0, 1, x_w(7, 0, 0));
        add(7'h17, 0, 1, x_f(8, 1)); add(7'h17, 0, 1, x_d(8));
        add(7'h17, 0, 1, x_e(8, 1, 1, 0, 0, 0, 0)); add(7'h17, 0, 1, x_w(8, 0, 0));
        add(7'h33, 0, 1, x_f(9, 1)); add(7'h33, 0, 1, x_d(9));
        add(7'h33, 0, 1, x_e(9, 0, 0, 2, 0, 0, 0)); add(7'h33, 0, 1, x_w(9, 0, 0));
        // FENCE as a 3-cycle NOP
        add(7'h0F, 0, 1, x_f(10, 1)); add(7'h0F, 0, 1, x_d(10));
        add(7'h0F, 0, 1, x_e(10, 0, 0, 0, 1, 0, 1));
        // Fetch stalls with timeout disabled, then an illegal opcode
        add(7'h7F, 0, 0, x_f(11, 0)); add(7'h7F, 0, 0, x_f(11, 0));
        add(7'h7F, 0, 1, x_f(11, 1)); add(7'h7F, 0, 1, x_d(11));

        for (int i = 0; i < tbl.size(); i++) step(1'b0, tbl[i].in, tbl[i].exp);

        // Trap is sticky for 20 cycles with no requests or writes
        for (int i = 0; i < 20; i++) step(1'b0, '{7'h7F, 1'($urandom_range(0, 1)), 1'b1}, x_t(11));
        reset_dut(1'b0);
        step(1'b0, '{7'h23, 1'b0, 1'b0}, x_f(0, 0));

        // Reset landing in MEM of a store abandons it
        step(1'b0, '{7'h23, 1'b0, 1'b1}, x_f(0, 1));
        step(1'b0, '{7'h23, 1'b0, 1'b1}, x_d(0));
        step(1'b0, '{7'h23, 1'b0, 1'b1}, x_e(0, 0, 1, 0, 0, 0, 0));
        rst0 = 1'b1;
        bus0.i_mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mem_state", 32'(bus0.o_state), 32'd3);
        chk("rst_mem_writes", 32'({bus0.o_pc_we, bus0.o_rf_we, bus0.o_retire}), 32'd0);
        @(posedge clk);
        #1;
        rst0 = 1'b0;
        step(1'b0, '{7'h23, 1'b0, 1'b0}, x_f(0, 0));

        // Timeout of 4 in FETCH traps after the 4th wait cycle
        reset_dut(1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, '{7'h03, 1'b0, 1'b0}, x_f(0, 0));
        step(1'b1, '{7'h03, 1'b0, 1'b0}, x_t(0));
        step(1'b1, '{7'h03, 1'b0, 1'b1}, x_t(0));

        // Ready on the 4th wait cycle wins; MEM stalls restart the count
        reset_dut(1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, '{7'h03, 1'b0, 1'b0}, x_f(0, 0));
        step(1'b1, '{7'h03, 1'b0, 1'b1}, x_f(0, 1));
        step(1'b1, '{7'h03, 1'b0, 1'b0}, x_d(0));
        step(1'b1, '{7'h03, 1'b0, 1'b0}, x_e(0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) step(1'b1, '{7'h03, 1'b0, 1'b0}, x_m(0, 0, 0));
        step(1'b1, '{7'h03, 1'b0, 1'b1}, x_m(0, 0, 0));
        step(1'b1, '{7'h03, 1'b0, 1'b0}, x_w(0, 1, 0));

        // Store stalling four cycles in MEM traps
        step(1'b1, '{7'h23, 1'b0, 1'b1}, x_f(1, 1));
        step(1'b1, '{7'h23, 1'b0, 1'b1}, x_d(1));
        step(1'b1, '{7'h23, 1'b0, 1'b1}, x_e(1, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) step(1'b1, '{7'h23, 1'b0, 1'b0}, x_m(1, 1, 0));
        step(1'b1, '{7'h23, 1'b0, 1'b1}, x_t(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
